// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes, ALUOp encodings, R-type funct codes, datapath defaults.
// Imported by the issue stage and any later stage that needs the ALU-control truth table.
package cpu_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_RADDR = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOP = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_RSVD   = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct to 4-bit ALU control translation, flagging unknown encodings.
// Zero latency; no flow control.
module alu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] control,
  output logic       illegal
);

  always_comb begin
    control = ALU_NOP;
    illegal = 1'b1;
    case (aluop)
      ALUOP_MEM: begin
        control = ALU_ADD;
        illegal = 1'b0;
      end
      ALUOP_BRANCH: begin
        control = ALU_SUB;
        illegal = 1'b0;
      end
      ALUOP_RTYPE: begin
        illegal = 1'b0;
        case (funct)
          FUNCT_ADD: control = ALU_ADD;
          FUNCT_SUB: control = ALU_SUB;
          FUNCT_AND: control = ALU_AND;
          FUNCT_OR:  control = ALU_OR;
          FUNCT_SLT: control = ALU_SLT;
          default: begin
            control = ALU_NOP;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        control = ALU_NOP;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU: operand forwarding, immediate select and ALU-control decode.
// One cycle latency; stall holds the slot, flush or reset loads a bubble (flush beats stall).
module alu_issue_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int RADDR = DEFAULT_RADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       aluop_in,
  input  logic [5:0]       funct_in,
  input  logic             alusrc_in,
  input  logic             regwrite_in,
  input  logic [RADDR-1:0] rs_addr_in,
  input  logic [RADDR-1:0] rt_addr_in,
  input  logic [RADDR-1:0] rd_addr_in,
  input  logic [XLEN-1:0]  rs_data_in,
  input  logic [XLEN-1:0]  rt_data_in,
  input  logic [XLEN-1:0]  imm_in,
  input  logic             exmem_regwrite,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_regwrite,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [XLEN-1:0]  memwb_result,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_out,
  output logic [3:0]       alu_control,
  output logic [XLEN-1:0]  alu_in1,
  output logic [XLEN-1:0]  alu_in2,
  output logic [XLEN-1:0]  store_data,
  output logic [RADDR-1:0] rd_out,
  output logic             regwrite_out,
  output logic             illegal
);

  typedef struct packed {
    logic             valid;
    logic [3:0]       control;
    logic [XLEN-1:0]  in1;
    logic [XLEN-1:0]  in2;
    logic [XLEN-1:0]  sdata;
    logic [RADDR-1:0] rd;
    logic             regwrite;
    logic             illegal;
  } slot_t;

  slot_t            slot_q;
  slot_t            slot_d;
  logic [3:0]       dec_control;
  logic             dec_illegal;
  logic [XLEN-1:0]  rs_fwd;
  logic [XLEN-1:0]  rt_fwd;
  logic             exmem_hit_rs, exmem_hit_rt, memwb_hit_rs, memwb_hit_rt;

  alu_ctrl_decode u_decode (
    .aluop   (aluop_in),
    .funct   (funct_in),
    .control (dec_control),
    .illegal (dec_illegal)
  );

  // x0 is hardwired, so a producer targeting it must never be forwarded.
  assign exmem_hit_rs = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_addr_in);
  assign exmem_hit_rt = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rt_addr_in);
  assign memwb_hit_rs = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_addr_in);
  assign memwb_hit_rt = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_addr_in);

  always_comb begin
    rs_fwd = rs_data_in;
    if (exmem_hit_rs)      rs_fwd = exmem_result;
    else if (memwb_hit_rs) rs_fwd = memwb_result;

    rt_fwd = rt_data_in;
    if (exmem_hit_rt)      rt_fwd = exmem_result;
    else if (memwb_hit_rt) rt_fwd = memwb_result;
  end

  always_comb begin
    slot_d          = '0;
    slot_d.valid    = 1'b1;
    slot_d.control  = dec_control;
    slot_d.in1      = rs_fwd;
    slot_d.in2      = alusrc_in ? imm_in : rt_fwd;
    slot_d.sdata    = rt_fwd;
    slot_d.rd       = rd_addr_in;
    slot_d.regwrite = regwrite_in && !dec_illegal;
    slot_d.illegal  = dec_illegal;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      slot_q <= '0;
    end else if (!stall) begin
      slot_q <= valid_in ? slot_d : '0;
    end
  end

  assign valid_out    = slot_q.valid;
  assign alu_control  = slot_q.control;
  assign alu_in1      = slot_q.in1;
  assign alu_in2      = slot_q.in2;
  assign store_data   = slot_q.sdata;
  assign rd_out       = slot_q.rd;
  assign regwrite_out = slot_q.regwrite;
  assign illegal      = slot_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode table, directed forwarding/stall/flush/ALU sequences, random vs model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, valid_in, alusrc_in, regwrite_in;
  logic [1:0]  aluop_in;
  logic [5:0]  funct_in;
  logic [4:0]  rs_addr_in, rt_addr_in, rd_addr_in;
  logic [31:0] rs_data_in, rt_data_in, imm_in;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        stall, flush;
  logic        valid_out, regwrite_out, illegal;
  logic [3:0]  alu_control;
  logic [31:0] alu_in1, alu_in2, store_data;
  logic [4:0]  rd_out;

  alu_issue_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .aluop_in(aluop_in), .funct_in(funct_in),
    .alusrc_in(alusrc_in), .regwrite_in(regwrite_in), .rs_addr_in(rs_addr_in),
    .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in), .rs_data_in(rs_data_in),
    .rt_data_in(rt_data_in), .imm_in(imm_in), .exmem_regwrite(exmem_regwrite),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result), .stall(stall), .flush(flush),
    .valid_out(valid_out), .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .store_data(store_data), .rd_out(rd_out), .regwrite_out(regwrite_out), .illegal(illegal)
  );

  // Downstream ALU behaviour: registers its result, holds it for control 1111.
  logic [31:0] alu_res;
  logic        alu_zero;
  always @(posedge clk) begin
    case (alu_control)
      4'b0000: alu_res <= alu_in1 & alu_in2;
      4'b0001: alu_res <= alu_in1 | alu_in2;
      4'b0010: alu_res <= alu_in1 + alu_in2;
      4'b0110: alu_res <= alu_in1 - alu_in2;
      4'b0111: alu_res <= ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
      default: alu_res <= alu_res;
    endcase
  end
  assign alu_zero = (alu_res == 32'd0);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  typedef struct packed {
    logic        v;
    logic [3:0]  ctrl;
    logic [31:0] a1, a2, sd;
    logic [4:0]  rd;
    logic        rw, ill;
  } slot_t;

  slot_t exp_s = '0;

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output logic [3:0] c, output logic ill);
    logic [5:0] fl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [3:0] cl [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
    c = 4'b1111;
    ill = 1'b1;
    if (op == 2'b00) begin c = 4'b0010; ill = 1'b0; end
    else if (op == 2'b01) begin c = 4'b0110; ill = 1'b0; end
    else if (op == 2'b10)
      for (int i = 0; i < 5; i++)
        if (f == fl[i]) begin c = cl[i]; ill = 1'b0; end
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return rf;
    if (exmem_regwrite && exmem_rd == a) return exmem_result;
    if (memwb_regwrite && memwb_rd == a) return memwb_result;
    return rf;
  endfunction

  // Predict the slot from the current inputs, clock once, then compare every output.
  task automatic step(input string tag);
    slot_t n;
    logic [3:0] c;
    logic il;
    logic [31:0] rs_v, rt_v;
    ref_decode(aluop_in, funct_in, c, il);
    rs_v = ref_fwd(rs_addr_in, rs_data_in);
    rt_v = ref_fwd(rt_addr_in, rt_data_in);
    if (reset || flush) n = '0;
    else if (stall) n = exp_s;
    else if (!valid_in) n = '0;
    else begin
      n.v = 1'b1; n.ctrl = c; n.a1 = rs_v; n.a2 = alusrc_in ? imm_in : rt_v;
      n.sd = rt_v; n.rd = rd_addr_in; n.rw = regwrite_in && !il; n.ill = il;
    end
    @(posedge clk);
    #1;
    exp_s = n;
    chk({tag, ".valid_out"},    {31'd0, valid_out},    {31'd0, n.v});
    chk({tag, ".alu_control"},  {28'd0, alu_control},  {28'd0, n.ctrl});
    chk({tag, ".alu_in1"},      alu_in1,               n.a1);
    chk({tag, ".alu_in2"},      alu_in2,               n.a2);
    chk({tag, ".store_data"},   store_data,            n.sd);
    chk({tag, ".rd_out"},       {27'd0, rd_out},       {27'd0, n.rd});
    chk({tag, ".regwrite_out"}, {31'd0, regwrite_out}, {31'd0, n.rw});
    chk({tag, ".illegal"},      {31'd0, illegal},      {31'd0, n.ill});
  endtask

  task automatic idle_inputs();
    reset = 0; valid_in = 0; aluop_in = 0; funct_in = 0; alusrc_in = 0; regwrite_in = 0;
    rs_addr_in = 0; rt_addr_in = 0; rd_addr_in = 0; rs_data_in = 0; rt_data_in = 0; imm_in = 0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0; stall = 0; flush = 0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] ctrl;
    logic       ill;
  } vec_t;

  vec_t vecs [9];
  logic [31:0] held1, held2;
  logic [5:0] fpool [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    vecs[0] = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    vecs[1] = '{2'b10, 6'b100010, 4'b0110, 1'b0};
    vecs[2] = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    vecs[3] = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    vecs[4] = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    vecs[5] = '{2'b10, 6'b000000, 4'b1111, 1'b1};
    vecs[6] = '{2'b00, 6'b000000, 4'b0010, 1'b0};
    vecs[7] = '{2'b01, 6'b111111, 4'b0110, 1'b0};
    vecs[8] = '{2'b11, 6'b100000, 4'b1111, 1'b1};

    // Reset held two cycles over a valid R-type add.
    idle_inputs();
    reset = 1; valid_in = 1; aluop_in = 2'b10; funct_in = 6'b100000; regwrite_in = 1;
    rs_addr_in = 5'd1; rt_addr_in = 5'd2; rd_addr_in = 5'd3;
    rs_data_in = 32'h10; rt_data_in = 32'h20;
    step("reset0");
    step("reset1");
    chk("reset.valid_out", {31'd0, valid_out}, 32'd0);
    reset = 0;
    step("post_reset");
    chk("post_reset.valid_out", {31'd0, valid_out}, 32'd1);
    chk("post_reset.ctrl", {28'd0, alu_control}, 32'h2);

    // Decode table.
    for (int i = 0; i < 9; i++) begin
      aluop_in = vecs[i].op; funct_in = vecs[i].f; regwrite_in = 1; valid_in = 1;
      step($sformatf("dec%0d", i));
      chk($sformatf("dec%0d.tbl_ctrl", i), {28'd0, alu_control}, {28'd0, vecs[i].ctrl});
      chk($sformatf("dec%0d.tbl_ill", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
      chk($sformatf("dec%0d.tbl_rw", i), {31'd0, regwrite_out}, {31'd0, !vecs[i].ill});
    end

    // Forwarding priority and x0 exclusion.
    aluop_in = 2'b10; funct_in = 6'b100000;
    rs_addr_in = 5'd5; rs_data_in = 32'h99;
    exmem_regwrite = 1; exmem_rd = 5'd5; exmem_result = 32'h11;
    memwb_regwrite = 1; memwb_rd = 5'd5; memwb_result = 32'h22;
    step("fwd_both");
    chk("fwd_both.in1", alu_in1, 32'h11);
    exmem_regwrite = 0;
    step("fwd_memwb");
    chk("fwd_memwb.in1", alu_in1, 32'h22);
    exmem_regwrite = 1; rs_addr_in = 5'd0; exmem_rd = 5'd0; memwb_rd = 5'd0;
    step("fwd_x0");
    chk("fwd_x0.in1", alu_in1, 32'h99);
    rs_addr_in = 5'd6; rt_addr_in = 5'd6; exmem_rd = 5'd6; exmem_result = 32'h77;
    step("fwd_same");
    chk("fwd_same.in1", alu_in1, 32'h77);
    chk("fwd_same.in2", alu_in2, 32'h77);

    // Load with immediate and forwarded store data.
    idle_inputs();
    valid_in = 1; aluop_in = 2'b00; alusrc_in = 1; imm_in = 32'hFFFF_FFFC; regwrite_in = 1;
    rt_addr_in = 5'd9; rt_data_in = 32'h1; exmem_regwrite = 1; exmem_rd = 5'd9; exmem_result = 32'h40;
    step("imm");
    chk("imm.in2", alu_in2, 32'hFFFF_FFFC);
    chk("imm.store", store_data, 32'h40);
    chk("imm.ctrl", {28'd0, alu_control}, 32'h2);

    // Stall holds across changing inputs; flush overrides stall.
    idle_inputs();
    valid_in = 1; aluop_in = 2'b01; rs_addr_in = 5'd3; rt_addr_in = 5'd4;
    rs_data_in = 32'hA5; rt_data_in = 32'h5A;
    step("sub");
    held1 = alu_in1; held2 = alu_in2;
    chk("sub.in1", held1, 32'hA5);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rs_data_in = $urandom; rt_data_in = $urandom; aluop_in = 2'($urandom);
      exmem_regwrite = 1; exmem_rd = 5'd3; exmem_result = $urandom;
      step($sformatf("stall%0d", i));
      chk($sformatf("stall%0d.in1", i), alu_in1, 32'hA5);
      chk($sformatf("stall%0d.in2", i), alu_in2, 32'h5A);
      chk($sformatf("stall%0d.ctrl", i), {28'd0, alu_control}, 32'h6);
    end
    flush = 1;
    step("stall_flush");
    chk("stall_flush.valid_out", {31'd0, valid_out}, 32'd0);
    flush = 0; stall = 0; aluop_in = 2'b00;
    step("reissue");
    stall = 1; reset = 1;
    step("stall_reset");
    chk("stall_reset.valid_out", {31'd0, valid_out}, 32'd0);

    // beq end-to-end through the ALU model.
    idle_inputs();
    valid_in = 1; aluop_in = 2'b01; rs_addr_in = 5'd7; rt_addr_in = 5'd7;
    rs_data_in = 32'h1234; rt_data_in = 32'h1234;
    step("beq");
    chk("beq.ctrl", {28'd0, alu_control}, 32'h6);
    valid_in = 0;
    step("beq_alu");
    chk("beq.zero", {31'd0, alu_zero}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 3);
      flush = ($urandom_range(0, 99) < 10);
      stall = ($urandom_range(0, 99) < 20);
      valid_in = ($urandom_range(0, 99) < 80);
      aluop_in = 2'($urandom);
      funct_in = ($urandom_range(0, 7) < 6) ? fpool[$urandom_range(0, 4)] : 6'($urandom);
      alusrc_in = 1'($urandom); regwrite_in = 1'($urandom);
      rs_addr_in = 5'($urandom_range(0, 3)); rt_addr_in = 5'($urandom_range(0, 3));
      rd_addr_in = 5'($urandom);
      rs_data_in = $urandom; rt_data_in = $urandom; imm_in = $urandom;
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      step($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
